// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core run-control slice: FSM encoding and syscall service codes.
package cpu_pkg;

  localparam int unsigned ST_W = 3;
  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] LED_SVC_DEFAULT = 32'd34;

  typedef enum logic [ST_W-1:0] {
    ST_RUN    = 3'd0,
    ST_PAUSED = 3'd1,
    ST_STEP   = 3'd2,
    ST_RESUME = 3'd3,
    ST_HALTED = 3'd4
  } run_state_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Core-facing bundle of the run-control unit: syscall/event inputs, enable, LED and counters.
interface cpu_run_ctrl_if
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NUM_EVT = 2
);

  logic                       syscall_i;
  logic [WORD_W-1:0]          svc_code_i;
  logic [WORD_W-1:0]          svc_arg_i;
  logic [NUM_EVT-1:0]         evt_i;
  logic                       clr_i;
  logic                       pc_enable_o;
  logic                       halted_o;
  logic                       led_we_o;
  logic [WORD_W-1:0]          led_data_o;
  logic [CNT_W-1:0]           cycles_o;
  logic [NUM_EVT*CNT_W-1:0]   evt_cnt_o;

  modport master (
    output syscall_i, svc_code_i, svc_arg_i, evt_i, clr_i,
    input  pc_enable_o, halted_o, led_we_o, led_data_o, cycles_o, evt_cnt_o
  );

  modport slave (
    input  syscall_i, svc_code_i, svc_arg_i, evt_i, clr_i,
    output pc_enable_o, halted_o, led_we_o, led_data_o, cycles_o, evt_cnt_o
  );

endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for a raw button level plus rising-edge detect (one pulse per press).
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev_c
);

  logic [2:0] sh_q;

  // [0],[1] synchronise; [2] holds the previous synchronised level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sh_q <= '0;
    else      sh_q <= {sh_q[1:0], btn};
  end

  assign ev_c = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control for the single-cycle MIPS core: pause/step/halt FSM, LED syscall service,
// and cycle/event performance counters.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned       CNT_W    = 32,
  parameter int unsigned       NUM_EVT  = 2,
  parameter logic [WORD_W-1:0] LED_SVC  = LED_SVC_DEFAULT,
  parameter bit                SAT_MODE = 1'b0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            pause_btn,
  input  logic            step_btn,
  cpu_run_ctrl_if.slave   bus
);

  run_state_t        state_q, state_d;
  logic              pause_ev, step_ev;
  logic              is_led_svc_c, halt_req_c, pc_en_c;
  logic [WORD_W-1:0] led_q;
  logic [NUM_EVT:0]  cnt_inc_c;

  btn_edge_sync u_pause_sync (.clk(clk), .rst(rst), .btn(pause_btn), .ev_c(pause_ev));
  btn_edge_sync u_step_sync  (.clk(clk), .rst(rst), .btn(step_btn),  .ev_c(step_ev));

  assign is_led_svc_c = (bus.svc_code_i == LED_SVC);
  assign halt_req_c   = bus.syscall_i & ~is_led_svc_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Next state and commit enable; STEP/RESUME always commit, even on a halting syscall
  always_comb begin
    state_d = state_q;
    pc_en_c = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        pc_en_c = ~halt_req_c;
        if (halt_req_c)    state_d = ST_HALTED;
        else if (pause_ev) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (pause_ev)     state_d = ST_RUN;
        else if (step_ev) state_d = ST_STEP;
      end
      ST_STEP: begin
        pc_en_c = 1'b1;
        state_d = ST_PAUSED;
      end
      ST_HALTED: begin
        if (pause_ev) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        pc_en_c = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               led_q <= '0;
    else if (bus.led_we_o)  led_q <= bus.svc_arg_i;
  end

  assign bus.pc_enable_o = pc_en_c;
  assign bus.halted_o    = (state_q == ST_HALTED);
  assign bus.led_we_o    = pc_en_c & bus.syscall_i & is_led_svc_c;
  assign bus.led_data_o  = led_q;

  // Channel 0 is the cycle counter; channel k+1 counts event k
  assign cnt_inc_c = {bus.evt_i & {NUM_EVT{pc_en_c}}, pc_en_c};

  for (genvar k = 0; k <= NUM_EVT; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)             cnt_q <= '0;
      else if (bus.clr_i)   cnt_q <= '0;
      else if (cnt_inc_c[k] && !(SAT_MODE && (&cnt_q)))
                            cnt_q <= cnt_q + CNT_W'(1);
    end

    if (k == 0) begin : g_cyc
      assign bus.cycles_o = cnt_q;
    end else begin : g_evt
      assign bus.evt_cnt_o[(k-1)*CNT_W +: CNT_W] = cnt_q;
    end
  end

endmodule
